coin_acceptor: RTL
==================

# coin_acceptor

Front-end stage of the candy vending machine: converts the two raw coin-sensor lines into clean, single coin events for the next-state logic. Synchronizes and debounces each sensor and resolves simultaneous or refused inserts. Queues accepted coins in a small FIFO and presents them one at a time on a valid/ready handshake. The downstream FSM register advances on `coin_valid && coin_ready` and takes `coin_type` as its `In` input.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized samples required before a debounced level changes; legal range 2–255.
- `FIFO_DEPTH`, 4: coin queue entries; must be a power of two, at least 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `re1_raw` in 1: Re1 coin sensor; asynchronous to `clk`; may bounce.
- `rs2_raw` in 1: Rs2 coin sensor; asynchronous to `clk`; may bounce.
- `accept_en` in 1: 1 = coins are accepted; 0 = every new coin is rejected.
- `coin_ready` in 1: downstream consumes the head coin this cycle.
- `coin_valid` out 1: FIFO non-empty; a head coin is presented.
- `coin_type` out 1: head coin type, 0 = Re1, 1 = Rs2; value is undefined when `coin_valid` = 0.
- `reject` out 1: one-cycle pulse; a detected coin was not queued and is routed to the return chute.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of queued coins.

## Operation
- **Synchronizer:** two-flop synchronizer on each raw line.
- **Debounce, per channel:** the debounced level `deb` and an 8-bit counter `cnt` run as follows:
  - sync output equal to `deb`: `cnt` clears.
  - sync output different from `deb` and `cnt` = DEBOUNCE_CYCLES-1: `deb` toggles and `cnt` clears.
  - otherwise: `cnt` increments.
- **Event detect:** `ev` = `deb` & ~`deb_q`, where `deb_q` is a one-cycle delayed copy of `deb`. Each channel therefore produces at most one event per debounced rising edge. Falling edges produce no event.
- **Arbitration, evaluated every cycle:**
  - Both channels have an event in the same cycle: the coin type is ambiguous. Neither is queued; `reject` pulses once.
  - One event with `accept_en` = 0: not queued; `reject` pulses.
  - One event with the FIFO full and no pop this cycle: not queued; `reject` pulses.
  - One event with the FIFO full and a pop this cycle: the push is accepted and `fifo_count` is unchanged.
  - Otherwise: push the type (0 for Re1, 1 for Rs2).
- **FIFO:**
  - Circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(FIFO_DEPTH) bits; both wrap modulo FIFO_DEPTH.
  - Pop = `coin_valid` && `coin_ready`. A pop while empty is ignored.
  - Push and pop in the same cycle while empty: not possible, because `coin_valid` = 0 when empty. The push lands and `fifo_count` becomes 1.
  - `coin_type` = mem[`rd_ptr`]. `coin_valid` = (`fifo_count` != 0).
  - Order is strictly first-in, first-out.
- **Handshake:**
  - `coin_valid` and `coin_type` stay stable until popped.
  - `coin_ready` may be held high continuously, giving one coin per cycle.
- **Reset:**
  - All synchronizer flops, `deb`, `deb_q` and `cnt` clear to 0.
  - Pointers and `fifo_count` clear to 0; `coin_valid` = 0 and `reject` = 0.
  - Reset asserted mid-operation takes effect immediately and discards every queued coin.
  - A sensor held high through reset release is debounced to 1 and produces exactly one event.

## Timing
- Raw line first sampled high at clock edge 1, held stable:
  - sync output high after edge 2;
  - `deb` high after edge 2+DEBOUNCE_CYCLES;
  - push at edge 3+DEBOUNCE_CYCLES;
  - `coin_valid` high after edge 3+DEBOUNCE_CYCLES.
- Any glitch shorter than DEBOUNCE_CYCLES synchronized samples clears `cnt` and produces no event.
- `reject` is registered: high for the one cycle after edge 3+DEBOUNCE_CYCLES.
- A pop at edge N: `fifo_count` decrements and the next head appears after edge N; `coin_valid` falls after edge N if the FIFO becomes empty.
- `fifo_count`, `coin_valid` and `reject` are all registered outputs. `coin_type` is a registered-memory read.

## Test plan
- **Single coin:** DEBOUNCE_CYCLES=4, `accept_en`=1, `coin_ready`=0. Hold `rs2_raw` high from edge 1 → `coin_valid`=1, `coin_type`=1 and `fifo_count`=1 after edge 7. `coin_ready`=1 for one cycle → `coin_valid`=0.
- **Bounce rejection:** toggle `re1_raw` high for 3 cycles, low for 1, repeated 5 times, then hold high → exactly one Re1 event, `fifo_count`=1.
- **Full FIFO:** FIFO_DEPTH=4, `coin_ready`=0. Insert coins Re1, Rs2, Re1, Rs2, Re1 → `fifo_count`=4 and `reject` pulses on the 5th. Then pop 4 with `coin_ready`=1 → `coin_type` sequence 0,1,0,1.
- **Full with same-cycle pop and push:** FIFO full; assert `coin_ready` on the same cycle a new Rs2 event arrives → no `reject`, `fifo_count` stays 4, and the new coin is last out.
- **Simultaneous insert and disabled acceptor:** both raw lines rise on the same edge → one `reject` pulse, `fifo_count`=0. With `accept_en`=0, a single Re1 insert → `reject` pulses, nothing queued.
- **Reset mid-operation:** with 3 coins queued and `cnt` mid-count, assert `rst_n`=0 → `coin_valid`, `fifo_count` and `reject` go to 0 immediately. After release with the lines low → no events.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor: sync + debounce two coin sensors, arbitrate,
// queue accepted coins and present them on a valid/ready port.
// Ports: clk, rst_n (async low), re1_raw, rs2_raw (raw sensors),
// accept_en, coin_ready (in); coin_valid, coin_type, reject,
// fifo_count (out, all registered).
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        re1_raw,
  input  logic                        rs2_raw,
  input  logic                        accept_en,
  input  logic                        coin_ready,
  output logic                        coin_valid,
  output logic                        coin_type,
  output logic                        reject,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // bit 0 = Re1, bit 1 = Rs2
  logic [1:0] raw;
  logic [1:0] s1_q, s2_q;
  logic [1:0] deb_q, deb_dly_q;
  logic [7:0] cnt_q [2];
  logic [1:0] ev;

  assign raw = {rs2_raw, re1_raw};
  assign ev  = deb_q & ~deb_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      deb_dly_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          deb_q[i] <= ~deb_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  logic          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   count_d;
  logic          full, pop;
  logic          both, one, blocked, ok;
  logic          push, rej_d;

  assign full    = (fifo_count == FULL_CNT);
  assign pop     = coin_valid & coin_ready;
  assign both    = &ev;
  assign one     = ^ev;
  // a full queue still takes a coin when the head leaves this cycle
  assign blocked = one & (~accept_en | (full & ~pop));
  assign ok      = one & ~blocked;

  always_comb begin
    push  = 1'b0;
    rej_d = 1'b0;
    unique case (1'b1)
      both:    rej_d = 1'b1;
      blocked: rej_d = 1'b1;
      ok:      push  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    count_d = fifo_count;
    unique case ({push, pop})
      2'b10:   count_d = fifo_count + 1'b1;
      2'b01:   count_d = fifo_count - 1'b1;
      default: count_d = fifo_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      fifo_count <= '0;
      coin_valid <= 1'b0;
      reject     <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= ev[1];
        wr_q        <= wr_q + AW'(1);
      end
      if (pop)
        rd_q <= rd_q + AW'(1);
      fifo_count <= count_d;
      coin_valid <= (count_d != '0);
      reject     <= rej_d;
    end
  end

  assign coin_type = mem_q[rd_q];

endmodule
